// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and FSM state encoding for the sequential 8-to-3 encoder
package enc_pkg;
    localparam int ENC_N      = 8;
    localparam int ENC_CODE_W = 3;
    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;
endpackage

// File: rtl/pri_enc8.sv
// pri_enc8: combinational 8-to-3 priority encoder with a one-hot clear mask for the selected bit
module pri_enc8 import enc_pkg::*; #(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic [ENC_N-1:0]      pending,
    output logic [ENC_CODE_W-1:0] code,
    output logic [ENC_N-1:0]      clr_mask
);
    // scan away from the winning end so the last hit is the priority index
    always_comb begin
        code = '0;
        for (int i = 0; i < ENC_N; i++) begin
            if (pending[PRIORITY_LSB ? ENC_N-1-i : i]) code = ENC_CODE_W'(PRIORITY_LSB ? ENC_N-1-i : i);
        end
        clr_mask = ENC_N'(1) << code;
    end
endmodule

// File: rtl/encoder_8to3_seq.sv
// encoder_8to3_seq: streams the set-bit indices of each accepted vector; ENC_LAST_EN adds out_last
module encoder_8to3_seq import enc_pkg::*; #(
    parameter int N            = 8,
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ENC_CODE_W-1:0] out_code,
    output logic                  err_zero
`ifdef ENC_LAST_EN
    ,
    output logic                  out_last
`endif
);
    logic             state;
    logic [ENC_N-1:0] pending;
    logic [ENC_N-1:0] clr_mask;
    logic [ENC_N-1:0] remain;

    pri_enc8 #(.PRIORITY_LSB(PRIORITY_LSB)) u_pri (
        .pending  (pending),
        .code     (out_code),
        .clr_mask (clr_mask)
    );

    assign in_ready  = state == IDLE;
    assign out_valid = state == BUSY;
    assign remain    = pending & ~clr_mask;
`ifdef ENC_LAST_EN
    assign out_last  = out_valid && $onehot(pending);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            err_zero <= 1'b0;
        end else begin
            err_zero <= in_ready && in_valid && in_data == '0;
            if (in_ready && in_valid && in_data != '0) begin
                pending <= in_data;
                state   <= BUSY;
            end else if (out_valid && out_ready) begin
                pending <= remain;
                state   <= remain == '0 ? IDLE : BUSY;
            end
        end
    end
endmodule

// File: tb/tb_encoder_8to3_seq.sv
// tb_encoder_8to3_seq: directed and random checks of both priority orders against a queue model
module tb_encoder_8to3_seq;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready_a, out_valid_a, err_zero_a;
    logic       in_ready_b, out_valid_b, err_zero_b;
    logic [2:0] out_code_a, out_code_b;
`ifdef ENC_LAST_EN
    logic       out_last_a, out_last_b;
`endif
    int checks = 0;
    int failures = 0;
    int qa[$];
    int qb[$];
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    encoder_8to3_seq #(.N(8), .PRIORITY_LSB(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_code(out_code_a), .err_zero(err_zero_a)
`ifdef ENC_LAST_EN
        , .out_last(out_last_a)
`endif
    );

    encoder_8to3_seq #(.N(8), .PRIORITY_LSB(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_code(out_code_b), .err_zero(err_zero_b)
`ifdef ENC_LAST_EN
        , .out_last(out_last_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference: a vector becomes the list of its set indices, popped one per output handshake
    task automatic model_edge();
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_err = 1'b0;
        end else begin
            exp_err = qa.size() == 0 && in_valid && in_data == 8'h00;
            if (qa.size() == 0) begin
                if (in_valid && in_data != 8'h00)
                    for (int i = 0; i < 8; i++)
                        if (in_data[i]) begin
                            qa.push_back(i);
                            qb.push_front(i);
                        end
            end else if (out_ready) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready_lsb", in_ready_a, qa.size() == 0);
        chk("in_ready_msb", in_ready_b, qb.size() == 0);
        chk("out_valid_lsb", out_valid_a, qa.size() != 0);
        chk("out_valid_msb", out_valid_b, qb.size() != 0);
        chk("out_code_lsb", out_code_a, qa.size() != 0 ? qa[0] : 0);
        chk("out_code_msb", out_code_b, qb.size() != 0 ? qb[0] : 0);
        chk("err_zero_lsb", err_zero_a, exp_err);
        chk("err_zero_msb", err_zero_b, exp_err);
`ifdef ENC_LAST_EN
        chk("out_last_lsb", out_last_a, qa.size() == 1);
        chk("out_last_msb", out_last_b, qb.size() == 1);
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = 8'h00;
        cycle(); cycle();
        chk("reset_code", out_code_a, 3'd0);
        chk("reset_ready", in_ready_a, 1'b1);
        rst = 1'b0;
        cycle();
        // multi-hot vector, both orders
        in_valid = 1'b1; in_data = 8'b1010_0100;
        cycle();
        in_valid = 1'b0; in_data = 8'h00;
        chk("s1_first_lsb", out_code_a, 3'd2);
        chk("s1_first_msb", out_code_b, 3'd7);
        cycle();
        chk("s1_second_lsb", out_code_a, 3'd5);
        chk("s1_second_msb", out_code_b, 3'd5);
        cycle();
        chk("s1_third_lsb", out_code_a, 3'd7);
        chk("s1_third_msb", out_code_b, 3'd2);
`ifdef ENC_LAST_EN
        chk("s1_last", out_last_a, 1'b1);
`endif
        cycle();
        chk("s1_ready_after", in_ready_a, 1'b1);
        // all-zero vector
        in_valid = 1'b1; in_data = 8'h00;
        cycle();
        in_valid = 1'b0;
        chk("s2_err", err_zero_a, 1'b1);
        chk("s2_valid", out_valid_a, 1'b0);
        cycle();
        chk("s2_err_clear", err_zero_a, 1'b0);
        // stall holds the code
        in_valid = 1'b1; in_data = 8'h81; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("s3_hold", out_code_a, 3'd0);
            if (i < 2) cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("s3_after_stall", out_code_a, 3'd7);
        cycle();
        // in_valid held high: no second vector until IDLE
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("s4_seq", out_code_a, i);
        end
        cycle();
        chk("s4_idle", in_ready_a, 1'b1);
        in_valid = 1'b0;
        cycle();
        // reset mid-burst
        in_valid = 1'b1; in_data = 8'hFF;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("s5_valid", out_valid_a, 1'b0);
        chk("s5_ready", in_ready_a, 1'b1);
        in_valid = 1'b1; in_data = 8'h10;
        cycle();
        in_valid = 1'b0;
        chk("s5_code", out_code_a, 3'd4);
        cycle();
        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = $urandom_range(0, 59) == 0;
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
            out_ready = $urandom_range(0, 9) < 7;
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encoder_8to3_seq.md
ENCODER_8TO3_SEQ -- requirements
Module: encoder_8to3_seq

Interface
- REQ-001: Parameter N, default 8, is the input request vector width; only 8 is supported.
- REQ-002: Parameter PRIORITY_LSB, default 1; 1 emits the lowest set index first, 0 emits the highest set index first.
- REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: in_valid  input  1  in_data is offered.
- REQ-006: in_ready  output  1  block can accept a vector.
- REQ-007: in_data  input  8  one-hot or multi-hot request vector.
- REQ-008: out_valid  output  1  out_code holds a valid index.
- REQ-009: out_ready  input  1  consumer accepts out_code.
- REQ-010: out_code  output  3  binary index of the selected set bit.
- REQ-011: err_zero  output  1  one-cycle pulse when an all-zero vector is accepted.
- REQ-012: out_last  output  1  marks the final index of a vector; present only when ENC_LAST_EN is defined.

Function
- REQ-013: The block SHALL implement two states, IDLE and BUSY, held in a state register.
- REQ-014: in_ready SHALL equal 1 exactly when state is IDLE.
- REQ-015: An input handshake occurs on a cycle with in_valid=1 and in_ready=1.
- REQ-016: On an input handshake with nonzero in_data, the block SHALL load in_data into an 8-bit pending register and enter BUSY.
- REQ-017: On an input handshake with in_data=0, the block SHALL pulse err_zero high for exactly the next cycle and remain in IDLE.
- REQ-018: In BUSY, out_valid SHALL be 1, and out_code SHALL be the priority-selected index of the pending register per PRIORITY_LSB.
- REQ-019: out_code and out_valid SHALL depend only on registered state, with no combinational path from in_data or in_valid.
- REQ-020: Latency: an input handshake at edge t SHALL present the first out_code in the cycle after t.
- REQ-021: On an output handshake (out_valid=1 and out_ready=1), the block SHALL clear the selected bit in pending.
- REQ-022: If the cleared bit was the last set bit, the block SHALL return to IDLE on the same edge.
- REQ-023: While out_valid=1 and out_ready=0, out_code SHALL remain stable.
- REQ-024: in_valid and in_data SHALL be ignored while in BUSY.
- REQ-025: Throughput: one code per cycle under continuous out_ready=1, plus one IDLE cycle between vectors.

Reset
- REQ-026: When rst=1 at a clock edge, state SHALL become IDLE, pending SHALL become 8'h00, and err_zero SHALL become 0.
- REQ-027: After reset, outputs SHALL be out_valid=0, out_code=3'd0, in_ready=1, and out_last=0.
- REQ-028: rst asserted mid-burst SHALL discard all remaining pending indices with no further out_valid.

Configuration
- REQ-029: When macro ENC_LAST_EN is defined, out_last SHALL equal 1 while out_valid=1 and pending has exactly one set bit, and 0 otherwise.
- REQ-030: When ENC_LAST_EN is undefined, the out_last port and its logic SHALL be absent, with all other behaviour unchanged.

Structure
- REQ-031: Package enc_pkg SHALL hold ENC_N=8, ENC_CODE_W=3, and the state encoding IDLE=1'b0, BUSY=1'b1.
- REQ-032: Sub-module pri_enc8 SHALL be a purely combinational 8-to-3 priority encoder.
  - pri_enc8 takes the pending register and PRIORITY_LSB and produces out_code.
  - pri_enc8 also produces a one-hot clear mask for the selected bit.

Verification
- REQ-033: Scenario: in_data=8'b1010_0100 with out_ready=1 -> out_code 2,5,7 on three consecutive cycles, out_last=1 on 7, in_ready=1 the cycle after.
- REQ-034: Scenario: in_data=8'h00 -> err_zero=1 for one cycle, out_valid stays 0, in_ready stays 1.
- REQ-035: Scenario: in_data=8'h81 with out_ready=0 for 3 cycles -> out_code=0 held stable for those 3 cycles, then 0 followed by 7 once out_ready=1.
- REQ-036: Scenario: in_data=8'hFF with in_valid held high throughout -> codes 0..7 in order, and no second vector is accepted until IDLE.
- REQ-037: Scenario: rst=1 after 2 codes of 8'hFF -> next cycle out_valid=0 and in_ready=1; a following in_data=8'h10 yields out_code=4.
- REQ-038: Scenario: PRIORITY_LSB=0 with in_data=8'b1010_0100 -> codes 7,5,2.
